// File: rtl/wm_sequencer.sv
// Washing-machine cycle sequencer: drives the phase code that Timer times,
// switches actuators per phase and guards each fill/heat phase with a watchdog.
module wm_sequencer #(
  parameter int unsigned RINSE_COUNT  = 2,
  parameter int unsigned TIMEOUT_W    = 12,
  parameter int unsigned FILL_TIMEOUT = 3000,
  parameter int unsigned HEAT_TIMEOUT = 4000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       cancel,
  input  logic       door_closed,
  input  logic       sig_Full,
  input  logic       sig_Temperature,
  input  logic       sig_Completed,
  output logic [2:0] state,
  output logic       door_lock,
  output logic       water_valve,
  output logic       heater,
  output logic       motor,
  output logic       drain_pump,
  output logic [2:0] rinse_idx,
  output logic       done,
  output logic       fault
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_HEAT  = 3'd2,
    S_WASH  = 3'd3,
    S_RINSE = 3'd4,
    S_DRAIN = 3'd5,
    S_DONE  = 3'd6,
    S_FAULT = 3'd7
  } phase_e;

  localparam logic [2:0] RINSE_TARGET = 3'(RINSE_COUNT);

  phase_e               state_q, state_d;
  logic                 entry_q, entry_d;
  logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
  logic [2:0]           rinse_q, rinse_d;
  logic                 washed_q, washed_d;
  logic                 fault_q, fault_d;
  logic                 done_q, done_d;
  logic [4:0]           act_q, act_d;    // {lock, valve, heater, motor, pump}

  logic                 timer_ok;
  logic                 locked;
  logic [31:0]          wdog_cnt;

  // Next phase and per-cycle bookkeeping.
  always_comb begin
    state_d  = state_q;
    rinse_d  = rinse_q;
    washed_d = washed_q;
    timer_ok = !entry_q;
    locked   = (state_q inside {S_FILL, S_HEAT, S_WASH, S_RINSE, S_DRAIN});
    wdog_cnt = 32'(wdog_q) + 32'd1;

    if (state_q == S_FAULT) begin
      state_d = S_FAULT;
    end else if (locked && !door_closed) begin
      state_d = S_FAULT;
    end else if (cancel && (state_q inside {S_FILL, S_HEAT, S_WASH, S_RINSE})) begin
      state_d = S_DRAIN;
      rinse_d = RINSE_TARGET;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start && door_closed) begin
            state_d  = S_FILL;
            rinse_d  = 3'd0;
            washed_d = 1'b0;
          end
        end
        // Refills after the main wash feed rinse passes; only the first heats.
        S_FILL: begin
          if (timer_ok && sig_Full)            state_d = washed_q ? S_RINSE : S_HEAT;
          else if (wdog_cnt >= FILL_TIMEOUT)   state_d = S_FAULT;
        end
        S_HEAT: begin
          if (timer_ok && sig_Temperature)     state_d = S_WASH;
          else if (wdog_cnt >= HEAT_TIMEOUT)   state_d = S_FAULT;
        end
        S_WASH: begin
          if (timer_ok && sig_Completed) begin
            state_d  = S_DRAIN;
            washed_d = 1'b1;
          end
        end
        S_RINSE: begin
          if (timer_ok && sig_Completed) begin
            state_d = S_DRAIN;
            if (rinse_q != 3'd7) rinse_d = rinse_q + 3'd1;
          end
        end
        S_DRAIN: begin
          if (timer_ok && sig_Completed) state_d = (rinse_q < RINSE_TARGET) ? S_FILL : S_DONE;
        end
        default: state_d = state_q;
      endcase
    end

    entry_d = (state_d != state_q);

    if (state_d != state_q)                        wdog_d = '0;
    else if (state_q == S_FILL || state_q == S_HEAT) wdog_d = (&wdog_q) ? wdog_q : wdog_q + TIMEOUT_W'(1);
    else                                           wdog_d = wdog_q;

    fault_d = fault_q | (state_d == S_FAULT);
    done_d  = (state_d == S_DONE);

    case (state_d)
      S_FILL:         act_d = 5'b11000;
      S_HEAT:         act_d = 5'b10100;
      S_WASH, S_RINSE: act_d = 5'b10010;
      S_DRAIN:        act_d = 5'b10001;
      default:        act_d = 5'b00000;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      entry_q  <= 1'b0;
      wdog_q   <= '0;
      rinse_q  <= 3'd0;
      washed_q <= 1'b0;
      fault_q  <= 1'b0;
      done_q   <= 1'b0;
      act_q    <= 5'b00000;
    end else begin
      state_q  <= state_d;
      entry_q  <= entry_d;
      wdog_q   <= wdog_d;
      rinse_q  <= rinse_d;
      washed_q <= washed_d;
      fault_q  <= fault_d;
      done_q   <= done_d;
      act_q    <= act_d;
    end
  end

  assign state       = state_q;
  assign door_lock   = act_q[4];
  assign water_valve = act_q[3];
  assign heater      = act_q[2];
  assign motor       = act_q[1];
  assign drain_pump  = act_q[0];
  assign rinse_idx   = rinse_q;
  assign done        = done_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_wm_sequencer.sv
// Directed and randomized checks of wm_sequencer against a phase-level reference model.
module tb_wm_sequencer;
  localparam int RC = 2;
  localparam int FT = 10;
  localparam int HT = 12;

  logic       clock = 1'b0;
  logic       reset, start, cancel, door_closed;
  logic       sig_Full, sig_Temperature, sig_Completed;
  logic [2:0] state, rinse_idx;
  logic       door_lock, water_valve, heater, motor, drain_pump, done, fault;

  wm_sequencer #(
    .RINSE_COUNT(RC), .TIMEOUT_W(12), .FILL_TIMEOUT(FT), .HEAT_TIMEOUT(HT)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .cancel(cancel),
    .door_closed(door_closed), .sig_Full(sig_Full),
    .sig_Temperature(sig_Temperature), .sig_Completed(sig_Completed),
    .state(state), .door_lock(door_lock), .water_valve(water_valve),
    .heater(heater), .motor(motor), .drain_pump(drain_pump),
    .rinse_idx(rinse_idx), .done(done), .fault(fault)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: phase number, cycles spent in the phase, rinse count,
  // whether the main wash has finished, sticky fault.
  int m_phase, m_tip, m_rinse;
  bit m_washed, m_fault;

  int seq[$];
  int fill_cycles, wash_cycles;
  int exp_seq[12] = '{0, 1, 2, 3, 5, 1, 4, 5, 1, 4, 5, 6};

  // {lock, valve, heater, motor, pump} per phase
  function automatic bit [4:0] acts(int p);
    case (p)
      1:       return 5'b11000;
      2:       return 5'b10100;
      3, 4:    return 5'b10010;
      5:       return 5'b10001;
      default: return 5'b00000;
    endcase
  endfunction

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int  nxt;
    bit  armed, lockd;
    if (reset) begin
      m_phase = 0; m_tip = 0; m_rinse = 0; m_washed = 0; m_fault = 0;
      return;
    end
    nxt   = m_phase;
    armed = (m_tip > 0);
    lockd = (m_phase >= 1 && m_phase <= 5);
    if (m_phase == 7) nxt = 7;
    else if (lockd && !door_closed) nxt = 7;
    else if (cancel && m_phase >= 1 && m_phase <= 4) begin
      nxt = 5; m_rinse = RC;
    end else begin
      case (m_phase)
        0, 6: if (start && door_closed) begin nxt = 1; m_rinse = 0; m_washed = 0; end
        1: begin
          if (armed && sig_Full) nxt = m_washed ? 4 : 2;
          else if (m_tip + 1 >= FT) nxt = 7;
        end
        2: begin
          if (armed && sig_Temperature) nxt = 3;
          else if (m_tip + 1 >= HT) nxt = 7;
        end
        3: if (armed && sig_Completed) begin nxt = 5; m_washed = 1; end
        4: if (armed && sig_Completed) begin nxt = 5; if (m_rinse < 7) m_rinse++; end
        5: if (armed && sig_Completed) nxt = (m_rinse < RC) ? 1 : 6;
        default: ;
      endcase
    end
    if (nxt == 7) m_fault = 1;
    m_tip   = (nxt == m_phase) ? m_tip + 1 : 0;
    m_phase = nxt;
  endtask

  task automatic check_all();
    bit [4:0] a;
    a = acts(m_phase);
    chk("state",       8'(state),       8'(m_phase));
    chk("door_lock",   8'(door_lock),   8'(a[4]));
    chk("water_valve", 8'(water_valve), 8'(a[3]));
    chk("heater",      8'(heater),      8'(a[2]));
    chk("motor",       8'(motor),       8'(a[1]));
    chk("drain_pump",  8'(drain_pump),  8'(a[0]));
    chk("rinse_idx",   8'(rinse_idx),   8'(m_rinse));
    chk("done",        8'(done),        8'(m_phase == 6));
    chk("fault",       8'(fault),       8'(m_fault));
  endtask

  task automatic cyc();
    @(posedge clock);
    model_step();
    #1;
    check_all();
    if (seq.size() == 0 || seq[$] != int'(state)) seq.push_back(int'(state));
    if (state == 3'd1) fill_cycles++;
    if (state == 3'd3) wash_cycles++;
  endtask

  // Irrelevant Timer signals are random noise; the one the phase listens to
  // rises dly cycles after entry unless hushed.
  task automatic drive_timers(int dly, bit hush);
    bit rel;
    sig_Full        = 1'($urandom_range(0, 1));
    sig_Temperature = 1'($urandom_range(0, 1));
    sig_Completed   = 1'($urandom_range(0, 1));
    rel = (m_tip >= dly) && !hush;
    case (m_phase)
      1:       sig_Full = rel;
      2:       sig_Temperature = rel;
      3, 4, 5: sig_Completed = rel;
      default: ;
    endcase
  endtask

  task automatic run_until(int target, int dly, bit hush, int bound);
    int k;
    k = 0;
    while (m_phase != target && k < bound) begin
      drive_timers(dly, hush);
      cyc();
      k++;
    end
    sig_Full = 0; sig_Temperature = 0; sig_Completed = 0;
    chk("reach_phase", 8'(state), 8'(target));
  endtask

  initial begin
    int n4;
    reset = 1; start = 0; cancel = 0; door_closed = 0;
    sig_Full = 0; sig_Temperature = 0; sig_Completed = 0;
    m_phase = 0; m_tip = 0; m_rinse = 0; m_washed = 0; m_fault = 0;

    // Reset state
    cyc(); cyc();
    reset = 0;
    cyc();

    // Nominal cycle with two rinses
    door_closed = 1;
    seq.delete();
    seq.push_back(int'(state));
    start = 1; cyc(); start = 0;
    run_until(6, 3, 0, 300);
    chk("nom_seq_len", 8'(seq.size()), 8'd12);
    for (int i = 0; i < 12; i++)
      if (i < seq.size()) chk("nom_seq", 8'(seq[i]), 8'(exp_seq[i]));
    chk("nom_rinse_idx", 8'(rinse_idx), 8'd2);
    chk("nom_done", 8'(done), 8'd1);
    chk("nom_door_lock", 8'(door_lock), 8'd0);

    // Start held from DONE, then cancel during WASH
    start = 1; cyc(); cyc(); cyc(); start = 0;
    chk("held_start_fill", 8'(state), 8'd1);
    run_until(3, 3, 0, 100);
    cancel = 1; cyc(); cancel = 0;
    chk("cancel_state", 8'(state), 8'd5);
    chk("cancel_pump", 8'(drain_pump), 8'd1);
    chk("cancel_motor", 8'(motor), 8'd0);
    seq.delete();
    run_until(6, 3, 0, 100);
    n4 = 0;
    foreach (seq[i]) if (seq[i] == 4) n4++;
    chk("cancel_no_rinse", 8'(n4), 8'd0);

    // Fill timeout
    fill_cycles = 0;
    start = 1; cyc(); start = 0;
    run_until(7, 3, 1, 50);
    chk("fill_to_cycles", 8'(fill_cycles), 8'(FT));
    chk("fill_to_fault", 8'(fault), 8'd1);
    chk("fill_to_acts", {3'b0, door_lock, water_valve, heater, motor, drain_pump}, 8'd0);
    start = 1; cyc(); cyc(); start = 0;
    chk("fault_ignores_start", 8'(state), 8'd7);
    reset = 1; cyc(); reset = 0;
    chk("fault_reset_state", 8'(state), 8'd0);
    chk("fault_reset_flag", 8'(fault), 8'd0);

    // Door opened in HEAT together with sig_Temperature
    start = 1; cyc(); start = 0;
    run_until(2, 3, 0, 50);
    cyc(); cyc();
    door_closed = 0; sig_Temperature = 1; cyc();
    chk("door_heat_fault", 8'(state), 8'd7);
    door_closed = 1; sig_Temperature = 0;
    reset = 1; cyc(); reset = 0;

    // Entry guard: sig_Completed held from the first WASH cycle
    start = 1; cyc(); start = 0;
    wash_cycles = 0;
    run_until(3, 3, 0, 50);
    sig_Completed = 1;
    for (int k = 0; k < 5 && state == 3'd3; k++) cyc();
    sig_Completed = 0;
    chk("entry_guard_wash", 8'(wash_cycles), 8'd2);
    run_until(6, 3, 0, 100);

    // Door open at start
    reset = 1; cyc(); reset = 0;
    door_closed = 0; start = 1; cyc(); start = 0;
    chk("door_open_state", 8'(state), 8'd0);
    chk("door_open_outs", {door_lock, water_valve, heater, motor, drain_pump, done, fault, 1'b0}, 8'd0);
    cyc();
    door_closed = 1; start = 1; cyc(); start = 0;
    chk("door_closed_start", 8'(state), 8'd1);

    // Randomized soak against the model
    for (int i = 0; i < 1500; i++) begin
      reset           = ($urandom_range(0, 59) == 0);
      start           = ($urandom_range(0, 7) == 0);
      cancel          = ($urandom_range(0, 39) == 0);
      door_closed     = ($urandom_range(0, 199) != 0);
      sig_Full        = ($urandom_range(0, 2) == 0);
      sig_Temperature = ($urandom_range(0, 2) == 0);
      sig_Completed   = ($urandom_range(0, 2) == 0);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
